// File: rtl/spi_bridge_pkg.sv
// Shared definitions for the SPI register-bank bridge.
//   - SPI command byte values
//   - top-level FSM state encoding (the stream fetcher decodes the STREAM_* states)
//   - status-byte bit positions and its builder
//   - register pointer increment with wrap
package spi_bridge_pkg;

  localparam logic [7:0] CMD_WR     = 8'h02;
  localparam logic [7:0] CMD_RD     = 8'h03;
  localparam logic [7:0] CMD_STAT   = 8'h0F;
  localparam logic [7:0] CMD_STREAM = 8'hCC;

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    WDATA,
    RADDR,
    RDATA,
    STREAM_P0,
    STREAM_WAIT,
    STREAM_P2
  } state_e;

  localparam int STAT_EMPTY_BIT    = 0;
  localparam int STAT_UNDERRUN_BIT = 1;

  function automatic logic [7:0] status_byte(input logic underrun, input logic fifo_empty);
    logic [7:0] s;
    s = 8'h00;
    s[STAT_UNDERRUN_BIT] = underrun;
    s[STAT_EMPTY_BIT]    = fifo_empty;
    return s;
  endfunction

  // The pointer wraps after the last register, and also after 8'hFF so that a burst
  // started out of range eventually comes back into the register file.
  function automatic logic [7:0] ptr_next(input logic [7:0] ptr, input int nreg);
    if ((ptr == 8'(nreg - 1)) || (ptr == 8'hFF)) begin
      return 8'h00;
    end
    return ptr + 8'h01;
  endfunction

endpackage

// File: rtl/spi_stream_fetch.sv
// Stream prefetch engine for the SPI register-bank bridge.
// Issues one FIFO pop per streamed byte, times the FIFO read latency with a
// down-counter, and keeps the sticky underrun flag.
// Ports:
//   clk, rst      system clock, async active-high reset
//   state         current bridge FSM state
//   ssel_n        chip select, active-low; high suppresses pops and underrun setting
//   fifo_dat      FIFO read data, valid FIFO_LAT cycles after fifo_rd
//   fifo_empty    FIFO empty flag
//   stat_clr      status read in progress: clear underrun (a coincident set wins)
//   fifo_rd       pop request, one cycle per STREAM_P0 visit with data available
//   lat_done      FIFO data valid this cycle (terminal count in STREAM_WAIT)
//   ld_vld        load ld_byte into tx_byte this cycle
//   ld_byte       FIFO data, or FILL_BYTE on underrun
//   underrun      sticky underrun flag
module spi_stream_fetch
  import spi_bridge_pkg::*;
#(
  parameter int         FIFO_LAT  = 1,
  parameter logic [7:0] FILL_BYTE = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  state_e     state,
  input  logic       ssel_n,
  input  logic [7:0] fifo_dat,
  input  logic       fifo_empty,
  input  logic       stat_clr,
  output logic       fifo_rd,
  output logic       lat_done,
  output logic       ld_vld,
  output logic [7:0] ld_byte,
  output logic       underrun
);

  // Counter starts at FIFO_LAT-1 on the pop so that terminal count lands on the
  // cycle fifo_dat becomes valid.
  localparam logic [1:0] LAT_LOAD = 2'(FIFO_LAT - 1);

  logic [1:0] lat_cnt_q, lat_cnt_d;
  logic       underrun_q, underrun_d;
  logic       pop_ok;
  logic       empty_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_cnt_q  <= 2'd0;
      underrun_q <= 1'b0;
    end else begin
      lat_cnt_q  <= lat_cnt_d;
      underrun_q <= underrun_d;
    end
  end

  always_comb begin
    pop_ok    = (state == STREAM_P0) && !ssel_n && !fifo_empty;
    empty_hit = (state == STREAM_P0) && !ssel_n && fifo_empty;
    lat_done  = (state == STREAM_WAIT) && (lat_cnt_q == 2'd0);

    lat_cnt_d = lat_cnt_q;
    if (pop_ok) begin
      lat_cnt_d = LAT_LOAD;
    end else if ((state == STREAM_WAIT) && (lat_cnt_q != 2'd0)) begin
      lat_cnt_d = lat_cnt_q - 2'd1;
    end

    underrun_d = underrun_q;
    if (stat_clr) begin
      underrun_d = 1'b0;
    end
    if (empty_hit) begin
      underrun_d = 1'b1;
    end
  end

  // A pop in flight when ssel_n rises reaches terminal count with ld_vld held low,
  // so its data is dropped.
  assign fifo_rd  = pop_ok;
  assign ld_vld   = empty_hit || (lat_done && !ssel_n);
  assign ld_byte  = lat_done ? fifo_dat : FILL_BYTE;
  assign underrun = underrun_q;

endmodule

// File: rtl/spi_regbank_bridge.sv
// SPI command decoder bridging a byte-level SPI slave to an NREG-byte register
// bank and the SDIO data FIFO. Supports burst write, burst read with pointer
// auto-increment, status read, and FIFO stream read until chip select rises.
// Build option: define SPI_REGBANK_WRLOCK_EN to make reg[0] bit 7 a write lock
// for reg[1..NREG-1].
// Ports:
//   clk, rst            system clock, async active-high reset
//   rx_vld, rx_byte     received MOSI byte strobe and data
//   tx_done             previous tx_byte fully shifted out
//   ssel_n              synchronised chip select, active-low
//   tx_byte             next byte for the slave to shift
//   reg_q               flat register image, reg k at [8k+7:8k]
//   reg_wr              per-register write strobe, coincident with reg_q update
//   fifo_rd, fifo_dat, fifo_empty   SDIO FIFO pop interface
//   underrun            sticky stream underrun flag
//   busy                FSM not in IDLE
//
// state       | meaning
// ------------+-----------------------------------------------------
// IDLE        | waiting for a command byte
// WADDR       | next rx byte is the write start address
// WDATA       | each rx byte is written at ptr, ptr increments
// RADDR       | next rx byte is the read start address
// RDATA       | each tx_done loads reg[ptr] into tx_byte, ptr increments
// STREAM_P0   | pop the FIFO, or load FILL_BYTE and flag underrun
// STREAM_WAIT | counting down the FIFO read latency
// STREAM_P2   | byte loaded, waiting for tx_done
module spi_regbank_bridge
  import spi_bridge_pkg::*;
#(
  parameter int                NREG      = 8,
  parameter int                FIFO_LAT  = 1,
  parameter logic [7:0]        FILL_BYTE = 8'hFF,
  parameter logic [NREG*8-1:0] RST_VAL   = {NREG{8'h00}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_vld,
  input  logic [7:0]        rx_byte,
  input  logic              tx_done,
  input  logic              ssel_n,
  output logic [7:0]        tx_byte,
  output logic [NREG*8-1:0] reg_q,
  output logic [NREG-1:0]   reg_wr,
  output logic              fifo_rd,
  input  logic [7:0]        fifo_dat,
  input  logic              fifo_empty,
  output logic              underrun,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [7:0]        ptr_q, ptr_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic [7:0]        regs_q [NREG];
  logic [7:0]        regs_d [NREG];
  logic [NREG-1:0]   reg_wr_q, reg_wr_d;

  logic              stat_clr;
  logic              lat_done;
  logic              ld_vld;
  logic [7:0]        ld_byte;
  logic [7:0]        rd_at_rx;
  logic [7:0]        rd_at_ptr;
  logic              wr_block;

  spi_stream_fetch #(
    .FIFO_LAT  (FIFO_LAT),
    .FILL_BYTE (FILL_BYTE)
  ) u_fetch (
    .clk        (clk),
    .rst        (rst),
    .state      (state_q),
    .ssel_n     (ssel_n),
    .fifo_dat   (fifo_dat),
    .fifo_empty (fifo_empty),
    .stat_clr   (stat_clr),
    .fifo_rd    (fifo_rd),
    .lat_done   (lat_done),
    .ld_vld     (ld_vld),
    .ld_byte    (ld_byte),
    .underrun   (underrun)
  );

`ifdef SPI_REGBANK_WRLOCK_EN
  assign wr_block = regs_q[0][7] && (ptr_q != 8'h00);
`else
  assign wr_block = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 8'h00;
      tx_byte_q <= 8'h00;
      reg_wr_q  <= '0;
      for (int k = 0; k < NREG; k++) begin
        regs_q[k] <= RST_VAL[8*k +: 8];
      end
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      tx_byte_q <= tx_byte_d;
      reg_wr_q  <= reg_wr_d;
      regs_q    <= regs_d;
    end
  end

  // Read ports; addresses that match no register read as 8'h00.
  always_comb begin
    rd_at_rx  = 8'h00;
    rd_at_ptr = 8'h00;
    for (int k = 0; k < NREG; k++) begin
      if (rx_byte == 8'(k)) begin
        rd_at_rx = regs_q[k];
      end
      if (ptr_q == 8'(k)) begin
        rd_at_ptr = regs_q[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (ssel_n) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_vld) begin
            case (rx_byte)
              CMD_WR:     state_d = WADDR;
              CMD_RD:     state_d = RADDR;
              CMD_STREAM: state_d = STREAM_P0;
              default:    state_d = IDLE;
            endcase
          end
        end
        WADDR:       if (rx_vld) state_d = WDATA;
        WDATA:       state_d = WDATA;
        RADDR:       if (rx_vld) state_d = RDATA;
        RDATA:       state_d = RDATA;
        STREAM_P0:   state_d = fifo_empty ? STREAM_P2 : STREAM_WAIT;
        STREAM_WAIT: if (lat_done) state_d = STREAM_P2;
        STREAM_P2:   if (tx_done) state_d = STREAM_P0;
        default:     state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ptr_d     = ptr_q;
    tx_byte_d = tx_byte_q;
    regs_d    = regs_q;
    reg_wr_d  = '0;
    stat_clr  = 1'b0;

    if (!ssel_n) begin
      case (state_q)
        IDLE: begin
          if (rx_vld) begin
            case (rx_byte)
              CMD_WR, CMD_RD, CMD_STREAM: ;
              CMD_STAT: begin
                tx_byte_d = status_byte(underrun, fifo_empty);
                stat_clr  = 1'b1;
              end
              default: tx_byte_d = FILL_BYTE;
            endcase
          end
        end
        WADDR: begin
          if (rx_vld) begin
            ptr_d = rx_byte;
          end
        end
        WDATA: begin
          if (rx_vld) begin
            // Out-of-range pointers match no k, so the write simply drops.
            for (int k = 0; k < NREG; k++) begin
              if ((ptr_q == 8'(k)) && !wr_block) begin
                regs_d[k]   = rx_byte;
                reg_wr_d[k] = 1'b1;
              end
            end
            ptr_d = ptr_next(ptr_q, NREG);
          end
        end
        RADDR: begin
          if (rx_vld) begin
            tx_byte_d = rd_at_rx;
            ptr_d     = ptr_next(rx_byte, NREG);
          end
        end
        RDATA: begin
          if (tx_done) begin
            tx_byte_d = rd_at_ptr;
            ptr_d     = ptr_next(ptr_q, NREG);
          end
        end
        default: begin
          if (ld_vld) begin
            tx_byte_d = ld_byte;
          end
        end
      endcase
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign reg_q[8*g +: 8] = regs_q[g];
  end

  assign tx_byte = tx_byte_q;
  assign reg_wr  = reg_wr_q;
  assign busy    = (state_q != IDLE);

endmodule
